// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results wait in a FIFO, and a starved FIFO head requests a pipeline bubble.
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_pipe_wren,
  input  logic [4:0]              i_pipe_rd,
  input  logic [31:0]             i_pipe_data,
  input  logic                    i_lu_valid,
  output logic                    o_lu_ready,
  input  logic [4:0]              i_lu_rd,
  input  logic [31:0]             i_lu_data,
  output logic                    o_rd_wren,
  output logic [4:0]              o_rd_addr,
  output logic [31:0]             o_rd_data,
  output logic                    o_pipe_stall,
  output logic [$clog2(DEPTH):0]  o_fifo_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  state_e             state_q, state_d;
  logic               wren_q, wren_d;
  logic [REG_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               stall_q, stall_d;

  logic   pipe_req;
  logic   push;
  logic   pop;
  entry_t head;

  // A pipeline write to x0 is no request at all and leaves the port to the FIFO.
  assign pipe_req   = i_pipe_wren && (i_pipe_rd != '0);
  assign o_lu_ready = (count_q < CNT_W'(DEPTH)) && !i_reset;
  assign push       = i_lu_valid && o_lu_ready;
  assign pop        = !pipe_req && (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Write-port mux; a popped head aimed at x0 is dropped silently.
  always_comb begin
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (pipe_req) begin
      wren_d = 1'b1;
      addr_d = i_pipe_rd;
      data_d = i_pipe_data;
    end else if (pop && (head.rd != '0)) begin
      wren_d = 1'b1;
      addr_d = head.rd;
      data_d = head.data;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (count_d != '0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          wait_d  = '0;
          state_d = (count_d == '0) ? ST_IDLE : ST_WAIT;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = ST_FORCE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FORCE: begin
        if (pop) begin
          wait_d  = '0;
          state_d = (count_d == '0) ? ST_IDLE : ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
    stall_d = (state_d == ST_FORCE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      state_q  <= ST_IDLE;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      state_q  <= state_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_t'{rd: i_lu_rd, data: i_lu_data};
  end

  assign o_rd_wren    = wren_q;
  assign o_rd_addr    = addr_q;
  assign o_rd_data    = data_q;
  assign o_pipe_stall = stall_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every register-file write with its cycle; a negedge monitor checks them.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wren;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        pipe_stall;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_pipe_wren  (pipe_wren),
    .i_pipe_rd    (pipe_rd),
    .i_pipe_data  (pipe_data),
    .i_lu_valid   (lu_valid),
    .o_lu_ready   (lu_ready),
    .i_lu_rd      (lu_rd),
    .i_lu_data    (lu_data),
    .o_rd_wren    (rd_wren),
    .o_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_pipe_stall (pipe_stall),
    .o_fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t mfifo[$];
  int   ungranted = 0;
  bit   stall_exp = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must be the next predicted one, on its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_wren) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected @cyc %0d: got rd=%0d data=%0h expected no write",
                   cyc, rd_addr, rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || rd_addr !== e.rd || rd_data !== e.data) begin
            n_fail++;
            $display("FAIL write @cyc %0d: got rd=%0d data=%0h expected cyc %0d rd=%0d data=%0h",
                     cyc, rd_addr, rd_data, e.cyc, e.rd, e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL write_missing @cyc %0d: got no write expected rd=%0d data=%0h",
                 cyc, e.rd, e.data);
      end
    end
  end

  // One clock cycle: check state, drive inputs, advance the reference model.
  task automatic step(input bit pw, input logic [4:0] prd, input logic [31:0] pdat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input bit r, output bit acc);
    bit   exp_ready;
    bit   nonempty;
    bit   popped;
    ent_t e;
    @(posedge clk);
    #1;
    check("fifo_count", 32'(fifo_count), 32'(mfifo.size()));
    check("pipe_stall", 32'(pipe_stall), 32'(stall_exp));
    rst       = r;
    pipe_wren = pw;
    pipe_rd   = prd;
    pipe_data = pdat;
    lu_valid  = lv;
    lu_rd     = lrd;
    lu_data   = ldat;
    #1;
    exp_ready = !r && (mfifo.size() < DEPTH);
    check("lu_ready", 32'(lu_ready), 32'(exp_ready));
    acc = lv && exp_ready;
    if (r) begin
      mfifo.delete();
      ungranted = 0;
      stall_exp = 1'b0;
    end else begin
      nonempty = mfifo.size() > 0;
      popped   = 1'b0;
      if (pw && prd != 5'd0) begin
        exp_q.push_back('{cyc + 1, prd, pdat});
      end else if (nonempty) begin
        e      = mfifo.pop_front();
        popped = 1'b1;
        if (e.rd != 5'd0) exp_q.push_back('{cyc + 1, e.rd, e.data});
      end
      if (popped || !nonempty) ungranted = 0;
      else                     ungranted++;
      stall_exp = ungranted >= MAX_WAIT;
      if (acc) mfifo.push_back('{lrd, ldat});
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, acc);
  endtask

  task automatic busy(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, 5'd3, $urandom, 1'b0, 5'd0, 32'd0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int guard;
    rst = 1'b1; pipe_wren = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    @(posedge clk);
    mon_en = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, acc);

    // Single result on an idle port: written two cycles after the push edge.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, acc);
    check("single_push_acc", 32'(acc), 32'd1);
    idle(4);

    // Pipeline hogs the port: the queued rd=7 starves until a bubble.
    step(1'b1, 5'd3, $urandom, 1'b1, 5'd7, 32'h0000_7777, 1'b0, acc);
    busy(11);
    idle(4);

    // Fill the FIFO while busy; a 5th result is held and accepted after the first pop.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'd3, $urandom, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b1, 5'd3, $urandom, 1'b1, 5'd5, 32'h105, 1'b0, acc);
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 10) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105, 1'b0, acc);
      guard++;
    end
    check("held_fifth_acc", 32'(acc), 32'd1);
    idle(8);

    // Full FIFO with an idle pipeline and a continuous push stream.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3, $urandom, 1'b1, 5'd11 + 5'(i), $urandom, 1'b0, acc);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20 + 5'(i), $urandom, 1'b0, acc);
    idle(8);

    // Pipeline write to x0 yields to rd=9; a queued x0 result produces no write.
    step(1'b1, 5'd3, $urandom, 1'b1, 5'd9, 32'h9999, 1'b0, acc);
    step(1'b1, 5'd0, 32'hBAD0, 1'b0, 5'd0, 32'd0, 1'b0, acc);
    step(1'b1, 5'd3, $urandom, 1'b1, 5'd0, 32'h0BAD, 1'b0, acc);
    idle(4);

    // Reset with three entries queued and the stall raised.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd3, $urandom, 1'b1, 5'd16 + 5'(i), $urandom, 1'b0, acc);
    busy(10);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, acc);
    idle(6);

    // Randomized traffic including x0 targets and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit          pw, lv, r;
      logic [4:0]  prd, lrd;
      pw  = ($urandom_range(99) < 55);
      prd = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
      lv  = ($urandom_range(99) < 45);
      lrd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      r   = ($urandom_range(299) == 0);
      step(pw, prd, $urandom, lv, lrd, $urandom, r, acc);
    end
    idle(12);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
